matrix_uart_formatter: RTL and testbench
========================================

// Module: matrix_uart_formatter
// PURPOSE
//  Sits downstream of the output mux. Takes one request per start pulse (element value + format flags),
//  converts the signed value to ASCII decimal, adds the sign and separator, and streams the bytes to
//  uart_tx over a valid/ready handshake. Single-entry: a new request is accepted only while idle.
// PARAMETERS
//  ELEM_W   8   width of matrix_element_t (two's complement, from project_pkg)
//  DIGITS   3   max decimal digits of |value|; must cover 2^(ELEM_W-1)
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst_n        in   1       synchronous, active-low reset
//  fmt_start    in   1       request pulse (from mux_sender_start)
//  fmt_data     in   ELEM_W  signed value / matrix ID / count
//  fmt_last_col in   1       row end: separator is CR LF, not ' '
//  fmt_newline  in   1       emit CR LF only; fmt_data ignored
//  fmt_id       in   1       ID format: '#' digits CR LF
//  fmt_sum_head in   1       summary head: 'S' digits ' '
//  fmt_sum_elem in   1       summary entry: digits, then '*' (or CR LF if last_col)
//  tx_data      out  8       byte to uart_tx
//  tx_valid     out  1       tx_data valid; held until tx_ready
//  tx_ready     in   1       uart_tx accepts byte this cycle
//  busy         out  1       request in flight; fmt_start ignored
//  done         out  1       1-cycle pulse after the final byte handshake
//  overrun      out  1       1-cycle pulse when fmt_start arrives while busy=1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; tx_data=0, tx_valid=0, busy=0, done=0, overrun=0.
//   Frame in flight is dropped silently; no partial byte is completed.
//  Accept: fmt_start=1 && busy=0 at edge T. Latch data + flags. busy=1 from T+1.
//  Flag priority when several are set: newline > id > sum_head > sum_elem > plain element.
//  Formats (bytes, in order):
//   plain:    ['-'] digits (' ' | CR LF if last_col)
//   newline:  CR(0x0D) LF(0x0A)
//   id:       '#' digits CR LF            (data treated as unsigned)
//   sum_head: 'S' digits ' '               (unsigned)
//   sum_elem: digits ('*' | CR LF if last_col) (unsigned)
//  Digits: leading zeros suppressed; value 0 prints "0"; -128 prints "-128" (magnitude in ELEM_W bits, unsigned).
//  FSM: IDLE -> CONV -> PREFIX -> DIGIT -> SEP1 -> SEP2 -> FIN -> IDLE.
//   CONV takes exactly ELEM_W cycles (T+1..T+ELEM_W). Newline skips CONV/PREFIX/DIGIT.
//   PREFIX covers '-', '#' or 'S' and is skipped if not needed. SEP2 only for CR LF.
//   FIN pulses done and clears busy. Skipped states are not entered and cost no cycles.
//  Latency: first tx_valid at T+ELEM_W+1 (newline: T+1). Each later byte is presented the cycle
//   after the previous handshake. done is high the cycle after the last handshake; busy=0 on the next.
//  Handshake: tx_data/tx_valid stay stable while tx_valid && !tx_ready. tx_ready is ignored
//   when tx_valid=0. There is no combinational path from tx_ready to tx_valid.
//  fmt_start while busy: request dropped, overrun pulses the next cycle, frame unaffected.
//  fmt_start in the done cycle is accepted: busy stays high and the new request starts normally.
// STRUCTURE
//  project_pkg: matrix_element_t, ELEM_W, ASCII_CR/LF/SP/MINUS/HASH/S/STAR, fmt_kind_t enum.
//  Sub-module bin2bcd_seq: iterative double-dabble.
//   Interface: start, bin[ELEM_W], bcd[4*DIGITS], done after ELEM_W cycles.
//  The formatter owns the FSM, digit index counter and leading-zero skip logic.
// TESTING
//  1) data=8'sd42, last_col=0, tx_ready=1 -> "42 " (0x34,0x32,0x20); done 1 cycle after last byte.
//  2) data=-128, last_col=1 -> "-128\r\n"; data=0 -> "0 "; data=-5 -> "-5 ".
//  3) newline=1, id=1, data=7 -> only 0x0D,0x0A; first tx_valid at T+1.
//  4) id=1, data=3 -> "#3\r\n"; sum_head data=12 -> "S12 "; sum_elem data=2, last_col=0 -> "2*".
//  5) tx_ready held low 5 cycles mid-frame -> tx_data stable, no byte lost or duplicated;
//     fmt_start during frame -> overrun pulse, output unchanged.
//  6) rst_n low for 1 cycle after the 2nd byte of "-128 " -> all outputs 0 next cycle;
//     a new request after reset formats correctly.

Source files
------------

// File: rtl/project_pkg.sv
// Shared types and constants for the matrix output path: element width,
// ASCII codes used by the UART formatter and the request/FSM enums.
package project_pkg;

    localparam int ELEM_W = 8;
    localparam int DIGITS = 3;

    typedef logic signed [ELEM_W-1:0] matrix_element_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        FK_PLAIN,
        FK_NEWLINE,
        FK_ID,
        FK_SUM_HEAD,
        FK_SUM_ELEM
    } fmt_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_PREFIX,
        ST_DIGIT,
        ST_SEP1,
        ST_SEP2,
        ST_FIN
    } fmt_state_t;

    // newline > id > sum_head > sum_elem > plain element
    function automatic fmt_kind_t decode_kind(input logic newline, input logic id,
                                              input logic sum_head, input logic sum_elem);
        fmt_kind_t k;
        if (newline)       k = FK_NEWLINE;
        else if (id)       k = FK_ID;
        else if (sum_head) k = FK_SUM_HEAD;
        else if (sum_elem) k = FK_SUM_ELEM;
        else               k = FK_PLAIN;
        return k;
    endfunction

endpackage

// File: rtl/matrix_uart_formatter_bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per cycle, ELEM_W cycles from start
// to a valid BCD result. done pulses in the cycle the result first becomes valid.
module bin2bcd_seq
    import project_pkg::*;
#(
    parameter int ELEM_W = project_pkg::ELEM_W,
    parameter int DIGITS = project_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ELEM_W-1:0]     bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CNT_W = $clog2(ELEM_W + 1);

    logic [ELEM_W-1:0]   shift_q, shift_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        // The first shift happens at load time: an all-zero BCD never needs the add-3.
        if (start) begin
            bcd_d   = {{(4*DIGITS-1){1'b0}}, bin[ELEM_W-1]};
            shift_d = bin << 1;
            cnt_d   = CNT_W'(ELEM_W - 1);
        end else if (cnt_q != '0) begin
            bcd_d   = {adj[4*DIGITS-2:0], shift_q[ELEM_W-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            done_d  = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/matrix_uart_formatter.sv
// Formats one matrix element / ID / summary request as ASCII decimal text and
// streams the bytes to uart_tx over a valid/ready handshake.
module matrix_uart_formatter
    import project_pkg::*;
#(
    parameter int ELEM_W = project_pkg::ELEM_W,
    parameter int DIGITS = project_pkg::DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fmt_start,
    input  logic [ELEM_W-1:0] fmt_data,
    input  logic              fmt_last_col,
    input  logic              fmt_newline,
    input  logic              fmt_id,
    input  logic              fmt_sum_head,
    input  logic              fmt_sum_elem,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    fmt_state_t       state_q, state_d;
    fmt_kind_t        kind_q, kind_d;
    logic             neg_q, neg_d;
    logic             crlf_q, crlf_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             overrun_q, overrun_d;

    fmt_kind_t           req_kind;
    logic                req_neg;
    logic                req_crlf;
    logic [ELEM_W-1:0]   conv_bin;
    logic                accept;
    logic                hs;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_done;
    logic [DIG_W-1:0]    lead_dig;
    logic [3:0]          cur_nib;

    // A request may land in the FIN cycle so back-to-back frames lose no cycle.
    assign accept = fmt_start && (state_q == ST_IDLE || state_q == ST_FIN);

    always_comb begin
        req_kind = decode_kind(fmt_newline, fmt_id, fmt_sum_head, fmt_sum_elem);
        req_neg  = (req_kind == FK_PLAIN) && fmt_data[ELEM_W-1];
        conv_bin = req_neg ? (~fmt_data) + ELEM_W'(1) : fmt_data;
        req_crlf = (req_kind == FK_NEWLINE) || (req_kind == FK_ID) ||
                   (((req_kind == FK_PLAIN) || (req_kind == FK_SUM_ELEM)) && fmt_last_col);
    end

    bin2bcd_seq #(
        .ELEM_W (ELEM_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (conv_bin),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    // Most significant non-zero digit; stays 0 for a zero value so "0" is printed.
    always_comb begin
        lead_dig = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                lead_dig = DIG_W'(i);
            end
        end
    end

    assign cur_nib = bcd[4*dig_q +: 4];

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            ST_PREFIX: begin
                tx_valid = 1'b1;
                if (neg_q)                tx_data = ASCII_MINUS;
                else if (kind_q == FK_ID) tx_data = ASCII_HASH;
                else                      tx_data = ASCII_S;
            end
            ST_DIGIT: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_ZERO + {4'h0, cur_nib};
            end
            ST_SEP1: begin
                tx_valid = 1'b1;
                if (crlf_q)                     tx_data = ASCII_CR;
                else if (kind_q == FK_SUM_ELEM) tx_data = ASCII_STAR;
                else                            tx_data = ASCII_SP;
            end
            ST_SEP2: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = '0;
            end
        endcase
    end

    assign hs      = tx_valid && tx_ready;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIN);
    assign overrun = overrun_q;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        neg_d     = neg_q;
        crlf_d    = crlf_q;
        dig_d     = dig_q;
        overrun_d = fmt_start && busy && (state_q != ST_FIN);

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CONV: begin
                if (bcd_done) begin
                    dig_d = lead_dig;
                    if (neg_q || kind_q == FK_ID || kind_q == FK_SUM_HEAD) state_d = ST_PREFIX;
                    else                                                  state_d = ST_DIGIT;
                end
            end
            ST_PREFIX: if (hs) state_d = ST_DIGIT;
            ST_DIGIT: begin
                if (hs) begin
                    if (dig_q == '0) state_d = ST_SEP1;
                    else             dig_d   = dig_q - DIG_W'(1);
                end
            end
            ST_SEP1: if (hs) state_d = crlf_q ? ST_SEP2 : ST_FIN;
            ST_SEP2: if (hs) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            kind_d  = req_kind;
            neg_d   = req_neg;
            crlf_d  = req_crlf;
            state_d = (req_kind == FK_NEWLINE) ? ST_SEP1 : ST_CONV;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= FK_PLAIN;
            neg_q     <= 1'b0;
            crlf_q    <= 1'b0;
            dig_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            neg_q     <= neg_d;
            crlf_q    <= crlf_d;
            dig_q     <= dig_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_matrix_uart_formatter.sv
// Directed bench for matrix_uart_formatter: hand-computed byte strings, latencies,
// backpressure, overrun, back-to-back requests and mid-frame reset.
module tb_matrix_uart_formatter;

    logic       clk;
    logic       rst_n;
    logic       fmt_start;
    logic [7:0] fmt_data;
    logic       fmt_last_col;
    logic       fmt_newline;
    logic       fmt_id;
    logic       fmt_sum_head;
    logic       fmt_sum_elem;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       overrun;

    int tests_run;
    int tests_failed;

    matrix_uart_formatter #(
        .ELEM_W (8),
        .DIGITS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fmt_start    (fmt_start),
        .fmt_data     (fmt_data),
        .fmt_last_col (fmt_last_col),
        .fmt_newline  (fmt_newline),
        .fmt_id       (fmt_id),
        .fmt_sum_head (fmt_sum_head),
        .fmt_sum_elem (fmt_sum_elem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Present one request for a single edge; returns #1 after that edge.
    task automatic start_req(input logic nl, input logic id, input logic sh, input logic se,
                             input logic lc, input logic [7:0] data);
        fmt_start    = 1'b1;
        fmt_newline  = nl;
        fmt_id       = id;
        fmt_sum_head = sh;
        fmt_sum_elem = se;
        fmt_last_col = lc;
        fmt_data     = data;
        @(posedge clk);
        #1;
        fmt_start    = 1'b0;
        fmt_newline  = 1'b0;
        fmt_id       = 1'b0;
        fmt_sum_head = 1'b0;
        fmt_sum_elem = 1'b0;
        fmt_last_col = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge. Returns in the done cycle.
    task automatic collect(input string tag, input string want, input int want_first,
                           input int stall_after, input int ovr_at);
        int n;
        int first;
        int done_cyc;
        int last_hs;
        int stall_cnt;
        bit stall_used;
        n = 0; first = -1; done_cyc = -1; last_hs = -1; stall_cnt = 0; stall_used = 0;
        check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            fmt_start   = 1'b0;
            fmt_newline = 1'b0;
            if (cyc == ovr_at) begin
                fmt_start   = 1'b1;
                fmt_newline = 1'b1;
                fmt_data    = 8'h55;
            end
            if (ovr_at > 0 && cyc == ovr_at + 1)
                check_eq({tag, "_overrun"}, 32'(overrun), 32'd1);
            if (!stall_used && stall_after >= 0 && n == stall_after && tx_valid) begin
                stall_cnt  = 5;
                stall_used = 1'b1;
            end
            tx_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            if (tx_valid && first < 0) first = cyc;
            if (tx_valid) begin
                if (n < want.len()) check_eq({tag, "_byte"}, 32'(tx_data), 32'(want[n]));
                else                check_eq({tag, "_extra_byte"}, 32'(tx_valid), 32'd0);
                if (tx_ready) begin
                    n++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        fmt_start   = 1'b0;
        fmt_newline = 1'b0;
        check_eq({tag, "_nbytes"}, 32'(n), 32'(want.len()));
        check_eq({tag, "_first_valid"}, 32'(first), 32'(want_first));
        check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(last_hs + 1));
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        check_eq({tag, "_done_off"}, 32'(done), 32'd0);
    endtask

    initial begin
        int hs;
        int saw_valid;
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; tx_ready = 1'b0; fmt_start = 1'b0; fmt_data = '0;
        fmt_last_col = 1'b0; fmt_newline = 1'b0; fmt_id = 1'b0;
        fmt_sum_head = 1'b0; fmt_sum_elem = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_req(0, 0, 0, 0, 0, 8'd42);
        collect("pos42", "42 ", 9, -1, -1);
        idle_check("pos42");

        start_req(0, 0, 0, 0, 1, 8'h80);
        collect("neg128", "-128\015\012", 9, -1, -1);
        idle_check("neg128");

        start_req(0, 0, 0, 0, 0, 8'd0);
        collect("zero", "0 ", 9, -1, -1);
        idle_check("zero");

        start_req(0, 0, 0, 0, 0, 8'hFB);
        collect("neg5", "-5 ", 9, -1, -1);
        idle_check("neg5");

        start_req(1, 1, 0, 0, 0, 8'd7);
        collect("newline", "\015\012", 1, -1, -1);
        idle_check("newline");

        start_req(0, 1, 0, 0, 0, 8'd3);
        collect("id3", "#3\015\012", 9, -1, -1);
        idle_check("id3");

        start_req(0, 1, 1, 1, 0, 8'hFF);
        collect("id255", "#255\015\012", 9, -1, -1);
        idle_check("id255");

        start_req(0, 0, 1, 0, 0, 8'd12);
        collect("sumhead12", "S12 ", 9, -1, -1);
        idle_check("sumhead12");

        start_req(0, 0, 0, 1, 1, 8'd200);
        collect("sumelem200", "200\015\012", 9, -1, -1);
        idle_check("sumelem200");

        // Request in the done cycle is accepted without a gap.
        start_req(0, 0, 0, 1, 0, 8'd2);
        collect("sumelem2", "2*", 9, -1, -1);
        start_req(1, 0, 0, 0, 0, 8'd0);
        collect("chain_nl", "\015\012", 1, -1, -1);
        idle_check("chain_nl");

        start_req(0, 0, 0, 0, 0, 8'hDB);
        collect("stall_neg37", "-37 ", 9, 1, 11);
        idle_check("stall_neg37");

        start_req(0, 0, 0, 0, 0, 8'h80);
        tx_ready = 1'b1;
        hs = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (tx_valid && tx_ready) hs++;
            if (hs == 2) break;
            @(posedge clk);
            #1;
        end
        check_eq("rst_mid_hs", 32'(hs), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
        check_eq("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        saw_valid = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (tx_valid || busy) saw_valid++;
        end
        check_eq("midrst_quiet", 32'(saw_valid), 32'd0);

        start_req(0, 0, 0, 0, 1, 8'd42);
        collect("after_rst", "42\015\012", 9, -1, -1);
        idle_check("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
